// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch front end.
//   br_mode_t     - branch target mode as driven on br_mode
//   fetch_state_t - request state (IDLE: nothing in flight, WAIT: one in flight)
//   INSTR_W       - instruction word width
//   branch_target - target address for a resolved taken branch, computed at
//                   MAX_ADDR_W bits; callers keep the low ADDR_W bits, which
//                   gives the modulo-2^ADDR_W wrap for free.
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        COND   = 2'd0,
        UNCOND = 2'd1,
        REG    = 2'd2
    } br_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    // Mode 3 is reserved and falls into the register-target case.
    function automatic logic [MAX_ADDR_W-1:0] branch_target(
        input logic [1:0]            mode,
        input logic [MAX_ADDR_W-1:0] pc,
        input logic [INSTR_W-1:0]    instr,
        input logic [MAX_ADDR_W-1:0] rval
    );
        logic [MAX_ADDR_W-1:0] off;
        case (mode)
            COND:    off = {{(MAX_ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};
            UNCOND:  off = {{(MAX_ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
            default: off = '0;
        endcase
        if (mode == COND || mode == UNCOND)
            return pc + off;
        else
            return {rval[MAX_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue with synchronous clear.
//   clk, reset     - clock, synchronous active-high reset (zeroes head too)
//   clr            - drop all entries (contents left stale, count -> 0)
//   push, din      - enqueue one entry; caller guarantees space
//   pop            - dequeue head; ignored when empty
//   valid, dout    - head entry; dout is entry 0 of a shifting register file,
//                    so it comes straight from a flop
//   count          - occupancy
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][WIDTH-1:0] ent;
    logic [CW-1:0]               cnt;
    logic                        do_pop;
    logic [CW-1:0]               wr_idx;

    assign do_pop = pop && (cnt != '0);
    // With a simultaneous pop the new word lands one slot lower.
    assign wr_idx = cnt - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            ent <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            assert (!(push && !do_pop && cnt == CW'(DEPTH)));
            if (do_pop)
                for (int i = 0; i < DEPTH-1; i++)
                    ent[i] <= ent[i+1];
            if (push)
                ent[wr_idx[CW-2:0]] <= din;
            cnt <= cnt + CW'(push) - CW'(do_pop);
        end
    end

    assign valid = (cnt != '0);
    assign dout  = ent[0];
    assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end with one outstanding memory request
// and a DEPTH-entry prefetch queue drained by decode.
//   clk, reset                  - clock, synchronous active-high reset
//   imem_req/imem_addr          - request out (accepted same cycle)
//   imem_rvalid/imem_rdata      - response in, >= 1 cycle after request
//   if_valid/if_ready/if_instr/if_pc - queue head to decode
//   redirect/br_mode/br_pc/br_instr/br_reg - taken branch: flush and refetch
//   q_count                     - queue occupancy
module fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [31:0]            if_instr,
    output logic [ADDR_W-1:0]      if_pc,
    input  logic                   redirect,
    input  logic [1:0]             br_mode,
    input  logic [ADDR_W-1:0]      br_pc,
    input  logic [31:0]            br_instr,
    input  logic [ADDR_W-1:0]      br_reg,
    output logic [$clog2(DEPTH):0] q_count
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t              state;
    logic [ADDR_W-1:0]         fetch_pc;
    logic [ADDR_W-1:0]         issue_pc;
    logic                      drop;
    logic                      pend;
    logic                      push;
    logic [MAX_ADDR_W-1:0]     target_full;
    logic [ADDR_W-1:0]         target;
    logic [ADDR_W+INSTR_W-1:0] head;

    assign target_full = branch_target(br_mode, MAX_ADDR_W'(br_pc), br_instr,
                                       MAX_ADDR_W'(br_reg));
    assign target      = target_full[ADDR_W-1:0];

    // The in-flight word needs a slot whether it is pushed this cycle or
    // still outstanding; only a word about to be discarded frees its slot.
    assign pend = (state == WAIT) && !(imem_rvalid && drop);

    assign imem_req  = !reset && !redirect && (state == IDLE || imem_rvalid) &&
                       ((q_count + CW'(pend)) < CW'(DEPTH));
    assign imem_addr = fetch_pc;

    assign push = (state == WAIT) && imem_rvalid && !drop && !redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            issue_pc <= '0;
            drop     <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= target;
            if (state == WAIT) begin
                if (imem_rvalid) begin
                    state <= IDLE;
                    drop  <= 1'b0;
                end else begin
                    drop  <= 1'b1;   // stale word still to come
                end
            end
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
                issue_pc <= fetch_pc;
                state    <= WAIT;
            end else if (state == WAIT && imem_rvalid) begin
                state    <= IDLE;
            end
            if (state == WAIT && imem_rvalid)
                drop <= 1'b0;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (redirect),
        .push  (push),
        .din   ({issue_pc, imem_rdata}),
        .pop   (if_ready),
        .valid (if_valid),
        .dout  (head),
        .count (q_count)
    );

    assign if_pc    = head[INSTR_W +: ADDR_W];
    assign if_instr = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          ADDR_W   = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        redirect;
    logic [1:0]  br_mode;
    logic [63:0] br_pc;
    logic [31:0] br_instr;
    logic [63:0] br_reg;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc),
        .redirect(redirect), .br_mode(br_mode), .br_pc(br_pc),
        .br_instr(br_instr), .br_reg(br_reg), .q_count(q_count)
    );

    // Instruction memory contents: a fixed function of the address.
    function automatic logic [31:0] mw(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    // Memory: one request at a time, responds 'lat' cycles after it is taken.
    int          lat  = 1;
    logic        busy = 1'b0;
    int          mcnt = 0;
    logic [63:0] raddr = '0;
    logic        spur = 1'b0;

    assign imem_rvalid = (busy && mcnt == 1) || spur;
    assign imem_rdata  = mw(raddr);

    always @(posedge clk) begin
        if (busy && mcnt == 1) busy <= 1'b0;
        if (busy && mcnt > 1)  mcnt <= mcnt - 1;
        if (imem_req) begin
            busy  <= 1'b1;
            mcnt  <= lat;
            raddr <= imem_addr;
        end
    end

    // Reference branch-target arithmetic.
    function automatic logic [63:0] tgt(input logic [1:0] m, input logic [63:0] pc,
                                        input logic [31:0] ins, input logic [63:0] r);
        logic signed [18:0] c;
        logic signed [25:0] u;
        c = ins[23:5];
        u = ins[25:0];
        if (m == 2'd0) return pc + 64'(longint'(c) * 4);
        if (m == 2'd1) return pc + 64'(longint'(u) * 4);
        return r - (r % 64'd4);
    endfunction

    // Model state: the next address fetched and the next PC decode should see.
    logic [63:0] exp_fetch = RESET_PC;
    logic [63:0] exp_dlv   = RESET_PC;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    // Called at the negedge: check this cycle against the model, then advance.
    task automatic fin();
        if (reset) begin
            chk("rst_noreq", 64'(imem_req), 64'd0);
            exp_fetch = RESET_PC;
            exp_dlv   = RESET_PC;
        end else begin
            chk("valid_vs_cnt", 64'(if_valid), 64'(q_count != 3'd0));
            chk("cnt_max", 64'(q_count <= 3'(DEPTH)), 64'd1);
            if (redirect) begin
                chk("redir_noreq", 64'(imem_req), 64'd0);
                exp_fetch = tgt(br_mode, br_pc, br_instr, br_reg);
                exp_dlv   = exp_fetch;
            end else begin
                if (imem_req) begin
                    chk("req_addr", imem_addr, exp_fetch);
                    exp_fetch = exp_fetch + 64'd4;
                end
                if (if_valid && if_ready) begin
                    chk("dlv_pc", if_pc, exp_dlv);
                    chk("dlv_instr", 64'(if_instr), 64'(mw(exp_dlv)));
                    exp_dlv = exp_dlv + 64'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    // Leaves the bench at the negedge of a cycle with imem_req high.
    task automatic wait_req(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            half();
            if (imem_req) got = 1'b1;
            else fin();
        end
        chk(tag, 64'(got), 64'd1);
        if (!got) half();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        reset = 1'b1; if_ready = 1'b0; redirect = 1'b0;
        br_mode = 2'd0; br_pc = '0; br_instr = '0; br_reg = '0;
        @(posedge clk); #1;

        // Reset state
        half();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 64'(if_valid), 64'd0);
        chk("rst_cnt", 64'(q_count), 64'd0);
        chk("rst_instr", 64'(if_instr), 64'd0);
        chk("rst_pc", if_pc, 64'd0);
        fin();

        // Streaming from RESET_PC with 1-cycle memory
        reset = 1'b0; if_ready = 1'b1; lat = 1;
        half();
        chk("s0_req", 64'(imem_req), 64'd1);
        chk("s0_addr", imem_addr, 64'h100);
        fin();
        half();
        chk("s1_req", 64'(imem_req), 64'd1);
        chk("s1_addr", imem_addr, 64'h104);
        chk("s1_valid", 64'(if_valid), 64'd0);
        fin();
        half();
        chk("s2_req", 64'(imem_req), 64'd1);
        chk("s2_addr", imem_addr, 64'h108);
        chk("s2_valid", 64'(if_valid), 64'd1);
        chk("s2_ifpc", if_pc, 64'h100);
        fin();

        // Decode stalled: queue fills to DEPTH, then resumes one per cycle
        if_ready = 1'b0;
        repeat (10) step();
        half();
        chk("full_cnt", 64'(q_count), 64'(DEPTH));
        chk("full_noreq", 64'(imem_req), 64'd0);
        fin();
        if_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            half();
            chk("resume_req", 64'(imem_req), 64'd1);
            fin();
        end

        // COND redirect, negative offset
        redirect = 1'b1; br_mode = 2'd0; br_pc = 64'h200;
        br_instr = {8'h00, 19'h7FFFD, 5'h00};
        half();
        chk("cond_noreq", 64'(imem_req), 64'd0);
        fin();
        redirect = 1'b0;
        half();
        chk("cond_addr", imem_addr, 64'h1F4);
        chk("cond_req", 64'(imem_req), 64'd1);
        chk("cond_cnt", 64'(q_count), 64'd0);
        chk("cond_valid", 64'(if_valid), 64'd0);
        fin();

        // REG redirect while a 3-cycle request is outstanding
        lat = 3;
        wait_req("reg_wait_req");
        fin();
        redirect = 1'b1; br_mode = 2'd2; br_reg = 64'h1003;
        step();
        redirect = 1'b0;
        half();
        chk("drop_noreq", 64'(imem_req), 64'd0);
        chk("drop_valid", 64'(if_valid), 64'd0);
        fin();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            half();
            if (if_valid) got = 1'b1;
            else fin();
        end
        chk("reg_got_valid", 64'(got), 64'd1);
        if (!got) half();
        chk("reg_ifpc", if_pc, 64'h1000);
        chk("reg_instr", 64'(if_instr), 64'(mw(64'h1000)));
        fin();

        // UNCOND redirect wrapping past 2^64
        redirect = 1'b1; br_mode = 2'd1; br_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        br_instr = {6'h00, 26'd2};
        step();
        redirect = 1'b0;
        wait_req("unc_wait_req");
        chk("unc_addr", imem_addr, 64'h4);
        fin();

        // Reset while a request is outstanding; a late response is ignored
        wait_req("rstw_wait_req");
        fin();
        reset = 1'b1;
        half();
        chk("rstw_noreq", 64'(imem_req), 64'd0);
        fin();
        reset = 1'b0; spur = 1'b1;
        half();
        chk("rstw_addr", imem_addr, RESET_PC);
        chk("rstw_req", 64'(imem_req), 64'd1);
        chk("rstw_cnt", 64'(q_count), 64'd0);
        chk("rstw_valid0", 64'(if_valid), 64'd0);
        fin();
        spur = 1'b0;
        half();
        chk("rstw_valid1", 64'(if_valid), 64'd0);
        fin();

        // Random traffic against the sequential-stream model
        for (int n = 0; n < 400; n++) begin
            lat      = int'($urandom_range(1, 3));
            if_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            br_mode  = 2'($urandom_range(0, 3));
            br_pc    = {$urandom, $urandom};
            br_instr = $urandom;
            br_reg   = {$urandom, $urandom};
            step();
        end
        redirect = 1'b0; if_ready = 1'b1;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
